load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Consumes the ALU result, either as an effective address (loads/stores) or as a pass-through value (all other instructions).
- Drives a single-outstanding request/acknowledge data-memory bus, then hands one completion record to writeback.
- Byte-lane steering, store strobes, load sign/zero extension, misalignment and bus-timeout faults are handled here.

Parameters:
ACK_TIMEOUT, 0, cycles to wait for mem_ack before faulting; 0 = wait forever

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream record valid
in_ready  out  1  stage can accept a record
in_load  in  1  record is a load
in_store  in  1  record is a store (in_load and in_store both 1 is illegal, treated as load)
in_size  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
in_result  in  32  ALU output: address for load/store, value otherwise
in_wdata  in  32  store data (rs2)
in_rd  in  5  destination register
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word address, bits [1:0] = 00
mem_strb  out  4  write byte enables (0000 on reads)
mem_wdata  out  32  lane-steered store data
mem_ack  in  1  bus completes the request this cycle
mem_rdata  in  32  read data, valid when mem_ack
out_valid  out  1  one-cycle completion pulse
out_we  out  1  writeback enable
out_rd  out  5  destination register
out_data  out  32  writeback value
out_fault  out  1  misaligned access or bus timeout

Behaviour:
- Reset: state IDLE. in_ready=1. mem_req=0, mem_we=0, mem_strb=0. out_valid=0, out_we=0, out_fault=0. mem_addr, mem_wdata, out_rd and out_data=0.
- Reset mid-transaction drops mem_req the next cycle; any late mem_ack is ignored.
- States: IDLE, ACCESS, DONE.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready; all in_* fields are captured on accept.
- IDLE, accept of a non-memory record -> DONE.
  - out_data=in_result, out_we=(rd!=0), fault=0.
  - Latency 1: out_valid in the cycle after accept.
- IDLE, accept of a load/store -> alignment check.
  - H/HU need addr[0]=0; W needs addr[1:0]=00.
  - Misaligned -> DONE with out_fault=1, out_we=0, out_data=in_result. No bus activity.
  - Aligned -> ACCESS. mem_req=1 from the cycle after accept.
  - mem_addr={addr[31:2],2'b00}; mem_we=store.
  - Store strobes: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111.
  - mem_wdata: byte/half replicated across lanes.
- ACCESS:
  - All mem_* outputs are held stable until the mem_ack cycle.
  - On mem_ack: mem_req drops the next cycle, go to DONE.
  - Load data: select the lane by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU); W is unchanged.
  - Load: out_we=(rd!=0). Store: out_we=0, out_data=0.
  - Minimum load/store latency: accept at T, mem_req at T+1, ack at T+1 earliest, out_valid at T+2.
- Timeout (ACK_TIMEOUT>0):
  - A counter runs in ACCESS starting at the first mem_req cycle.
  - If ACK_TIMEOUT cycles pass without ack, drop mem_req and go to DONE with out_fault=1, out_we=0.
  - mem_ack arriving in the same cycle as expiry wins: normal completion.
- DONE: out_valid=1 for exactly one cycle, then IDLE. Writeback never stalls.
  - in_ready is 0 in DONE, so maximum throughput is one record per 2 cycles (non-memory) or per 3+ cycles (memory).
- out_* fields other than out_valid hold their last values between pulses. out_we and out_fault are meaningful only with out_valid.
- mem_ack outside ACCESS is ignored.

Test Plan:
- Pass-through: accept result=0x0000_1234, rd=5, no load/store -> out_valid next cycle, out_data=0x1234, out_we=1, no mem_req; repeat with rd=0 -> out_we=0.
- Store byte: addr=0x103, wdata=0xAABBCCDD, size B, ack 2 cycles later -> mem_addr=0x100, mem_strb=1000, mem_wdata=0xDDDDDDDD, mem_we=1 held until ack; then out_valid, out_we=0.
- Load sign/zero: mem_rdata=0x80FF_7F01 at addr 0x202. LH -> 0xFFFF80FF; LHU -> 0x000080FF; LB at 0x200 -> 0x00000001; LW at 0x200 -> 0x80FF7F01.
- Misaligned LW at 0x101 -> no mem_req ever; out_valid the cycle after accept, out_fault=1, out_we=0.
- Timeout with ACK_TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then out_valid with out_fault=1; separate run with ack on the 4th cycle -> normal completion, fault=0.
- Reset asserted during ACCESS -> next cycle mem_req=0, in_ready=1, out_valid=0; an ack arriving after reset produces no out_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: lane steering, extension, faults, one completion per record
module load_store_unit #(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_size,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic        out_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        is_load_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] cnt;

  logic        acc_mem;
  logic        acc_store;
  logic        misaligned;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic        expired;

  assign in_ready = (state == IDLE);

  // Decode the incoming record: alignment, byte enables and replicated store data.
  // A record flagged as both load and store is handled as a load.
  always_comb begin
    acc_mem   = in_load | in_store;
    acc_store = in_store & ~in_load;
    case (in_size[1:0])
      2'b00: begin
        misaligned = 1'b0;
        strb_n     = 4'b0001 << in_result[1:0];
        wdata_n    = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = in_result[0];
        strb_n     = 4'b0011 << in_result[1:0];
        wdata_n    = {2{in_wdata[15:0]}};
      end
      default: begin
        misaligned = |in_result[1:0];
        strb_n     = 4'b1111;
        wdata_n    = in_wdata;
      end
    endcase
  end

  // Pick the addressed lane from read data and extend it to 32 bits.
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q[1:0])
      2'b00:   load_val = size_q[2] ? {24'b0, lane[7:0]}   : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_val = size_q[2] ? {16'b0, lane[15:0]}  : {{16{lane[15]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // Timeout fires on the last permitted request cycle unless the ack arrives with it.
  always_comb begin
    expired = (ACK_TIMEOUT > 0) && (cnt == 32'(ACK_TIMEOUT - 1));
  end

  // Stage FSM; every bus and writeback output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_load_q <= 1'b0;
      size_q    <= 3'b0;
      addr_q    <= 32'b0;
      cnt       <= 32'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_strb  <= 4'b0;
      mem_wdata <= 32'b0;
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      out_rd    <= 5'b0;
      out_data  <= 32'b0;
      out_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            is_load_q <= in_load;
            size_q    <= in_size;
            addr_q    <= in_result;
            out_rd    <= in_rd;
            cnt       <= 32'b0;
            if (!acc_mem || misaligned) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_fault <= acc_mem;
              out_we    <= ~acc_mem & (|in_rd);
              out_data  <= in_result;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= acc_store;
              mem_addr  <= {in_result[31:2], 2'b00};
              mem_strb  <= acc_store ? strb_n : 4'b0000;
              mem_wdata <= wdata_n;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_strb  <= 4'b0;
            out_valid <= 1'b1;
            out_fault <= 1'b0;
            out_we    <= is_load_q & (|out_rd);
            out_data  <= is_load_q ? load_val : 32'b0;
          end else if (expired) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_strb  <= 4'b0;
            out_valid <= 1'b1;
            out_fault <= 1'b1;
            out_we    <= 1'b0;
            out_data  <= addr_q;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
